// File: rtl/io_pkg.sv
// Shared IO-bus package: bus field widths, GPIO register offsets and word-address decode helper.
package io_pkg;

  localparam int unsigned IO_ADR_W   = 14;
  localparam int unsigned IO_DATA_W  = 32;
  localparam int unsigned GPIO_OFS_W = 3;
  localparam int unsigned GPIO_NREG  = 8;

  localparam logic [GPIO_OFS_W-1:0] GPIO_OFS_OUT     = 3'd0;
  localparam logic [GPIO_OFS_W-1:0] GPIO_OFS_IN      = 3'd1;
  localparam logic [GPIO_OFS_W-1:0] GPIO_OFS_EN      = 3'd2;
  localparam logic [GPIO_OFS_W-1:0] GPIO_OFS_OUT_SET = 3'd3;
  localparam logic [GPIO_OFS_W-1:0] GPIO_OFS_OUT_CLR = 3'd4;
  localparam logic [GPIO_OFS_W-1:0] GPIO_OFS_RISE_EN = 3'd5;
  localparam logic [GPIO_OFS_W-1:0] GPIO_OFS_FALL_EN = 3'd6;
  localparam logic [GPIO_OFS_W-1:0] GPIO_OFS_IRQ     = 3'd7;

  // Decoded bus access: hit within the register window and register offset.
  typedef struct packed {
    logic                  hit;
    logic [GPIO_OFS_W-1:0] ofs;
  } io_dec_t;

  function automatic io_dec_t io_decode(input logic [IO_ADR_W-1:0] adr,
                                        input logic [IO_ADR_W-1:0] base);
    logic [IO_ADR_W-1:0] delta;
    io_dec_t             dec;
    delta   = adr - base;
    dec.hit = (delta < IO_ADR_W'(GPIO_NREG));
    dec.ofs = delta[GPIO_OFS_W-1:0];
    return dec;
  endfunction

endpackage

// File: rtl/io_gpio_sync_deb.sv
// One GPIO input: SYNC_STAGES-deep synchroniser, plus a per-pin debounce filter when
// IO_GPIO_DEBOUNCE_EN is defined (otherwise the synchroniser output is used directly).
module io_gpio_sync_deb #(
  parameter int unsigned SYNC_STAGES = 2
`ifdef IO_GPIO_DEBOUNCE_EN
  , parameter int unsigned DEB_CNT_W = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic f_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IO_GPIO_DEBOUNCE_EN
  // Accept a new level only after 2**DEB_CNT_W-1 consecutive differing cycles.
  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'((2 ** DEB_CNT_W) - 2);

  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 f_q, f_d;

  always_comb begin
    cnt_d = '0;
    f_d   = f_q;
    if (sync_out != f_q) begin
      if (cnt_q == CNT_LAST) f_d = sync_out;
      else                   cnt_d = cnt_q + DEB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      f_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      f_q   <= f_d;
    end
  end

  assign f_o = f_q;
`else
  assign f_o = sync_out;
`endif

endmodule

// File: rtl/io_gpio_irq.sv
// GPIO block on the dma_io bus: tri-state pins, atomic set/clr, edge capture and level irq.
// Optional per-pin debounce filter enabled by defining IO_GPIO_DEBOUNCE_EN.
module io_gpio_irq
  import io_pkg::*;
#(
  parameter int unsigned GPIO_W      = 8,
  parameter logic [13:0] BASE_ADR    = 14'h3F88,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dma_io_we,
  input  logic [15:2]        dma_io_wadr,
  input  logic [31:0]        dma_io_wdata,
  input  logic [15:2]        dma_io_radr,
  input  logic               dma_io_radr_en,
  input  logic [31:0]        dma_io_rdata_in,
  output logic [31:0]        dma_io_rdata,
  inout  wire  [GPIO_W-1:0]  gpio,
  output logic               gpio_irq
);

`ifdef IO_GPIO_DEBOUNCE_EN
  localparam int unsigned DEB_ARM_EXT = 2 ** DEB_CNT_W;
`else
  localparam int unsigned DEB_ARM_EXT = DEB_CNT_W - DEB_CNT_W;
`endif
  // Edge detection stays off until the input pipeline has flushed its reset state.
  localparam int unsigned ARM_MAX = SYNC_STAGES + 1 + DEB_ARM_EXT;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

  logic [GPIO_W-1:0]    out_q, out_d;
  logic [GPIO_W-1:0]    en_q, en_d;
  logic [GPIO_W-1:0]    rise_en_q, rise_en_d;
  logic [GPIO_W-1:0]    fall_en_q, fall_en_d;
  logic [GPIO_W-1:0]    irq_stat_q, irq_stat_d;
  logic [GPIO_W-1:0]    f_dly_q, f_dly_d;
  logic [ARM_W-1:0]     arm_q, arm_d;
  logic [IO_DATA_W-1:0] rdata_q, rdata_d;
  logic                 rd_hit_q, rd_hit_d;
  logic                 irq_q, irq_d;

  logic [GPIO_W-1:0]    pin_f;
  logic [GPIO_W-1:0]    wdata_g;
  logic [GPIO_W-1:0]    rise_evt, fall_evt, irq_clr, rd_val;
  logic                 armed, wr_hit;
  io_dec_t              wr_dec, rd_dec;
  logic                 unused_wdata;

  assign unused_wdata = ^dma_io_wdata;
  assign wdata_g      = dma_io_wdata[GPIO_W-1:0];
  assign wr_dec       = io_decode(dma_io_wadr, BASE_ADR);
  assign rd_dec       = io_decode(dma_io_radr, BASE_ADR);
  assign wr_hit       = dma_io_we & wr_dec.hit;

  for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
    io_gpio_sync_deb #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef IO_GPIO_DEBOUNCE_EN
      , .DEB_CNT_W(DEB_CNT_W)
`endif
    ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .pin_i (gpio[i]),
      .f_o   (pin_f[i])
    );
    assign gpio[i] = en_q[i] ? out_q[i] : 1'bz;
  end

  // Register writes, edge capture and interrupt status.
  always_comb begin
    out_d     = out_q;
    en_d      = en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_clr   = '0;
    armed     = (arm_q == ARM_W'(ARM_MAX));
    arm_d     = armed ? arm_q : arm_q + ARM_W'(1);
    f_dly_d   = pin_f;
    rise_evt  = armed ? (pin_f & ~f_dly_q & rise_en_q) : '0;
    fall_evt  = armed ? (~pin_f & f_dly_q & fall_en_q) : '0;

    if (wr_hit) begin
      case (wr_dec.ofs)
        GPIO_OFS_OUT:     out_d     = wdata_g;
        GPIO_OFS_EN:      en_d      = wdata_g;
        GPIO_OFS_OUT_SET: out_d     = out_q | wdata_g;
        GPIO_OFS_OUT_CLR: out_d     = out_q & ~wdata_g;
        GPIO_OFS_RISE_EN: rise_en_d = wdata_g;
        GPIO_OFS_FALL_EN: fall_en_d = wdata_g;
        GPIO_OFS_IRQ:     irq_clr   = wdata_g;
        default:          ;
      endcase
    end

    // New events win over a same-cycle W1C.
    irq_stat_d = (irq_stat_q & ~irq_clr) | rise_evt | fall_evt;
    irq_d      = |irq_stat_q;
  end

  // Read mux samples pre-write register values.
  always_comb begin
    rd_val = '0;
    case (rd_dec.ofs)
      GPIO_OFS_OUT:     rd_val = out_q;
      GPIO_OFS_IN:      rd_val = pin_f;
      GPIO_OFS_EN:      rd_val = en_q;
      GPIO_OFS_RISE_EN: rd_val = rise_en_q;
      GPIO_OFS_FALL_EN: rd_val = fall_en_q;
      GPIO_OFS_IRQ:     rd_val = irq_stat_q;
      default:          rd_val = '0;
    endcase
    rd_hit_d = dma_io_radr_en & rd_dec.hit;
    rdata_d  = rd_hit_d ? IO_DATA_W'(rd_val) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      en_q       <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_stat_q <= '0;
      f_dly_q    <= '0;
      arm_q      <= '0;
      rdata_q    <= '0;
      rd_hit_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      en_q       <= en_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_stat_q <= irq_stat_d;
      f_dly_q    <= f_dly_d;
      arm_q      <= arm_d;
      rdata_q    <= rdata_d;
      rd_hit_q   <= rd_hit_d;
      irq_q      <= irq_d;
    end
  end

  assign dma_io_rdata = rd_hit_q ? rdata_q : dma_io_rdata_in;
  assign gpio_irq     = irq_q;

endmodule
